// File: rtl/hash_pkg.sv
// hash_pkg: shared types and helpers for the parametrised byte hash core.
//   hash_state_e - controller state encoding
//   SBOX_TABLE   - AES forward S-box
//   sbox()       - table lookup
//   rotl8()      - 8-bit rotate-left by 0..7
//   LEN_BYTES    - number of big-endian length bytes absorbed at finalisation
package hash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_ABSORB = 3'd2,
        ST_ROUND  = 3'd3,
        ST_FINAL  = 3'd4,
        ST_DONE   = 3'd5
    } hash_state_e;

    localparam int LEN_BYTES = 8;

    localparam logic [7:0] SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[x];
    endfunction

    // Rotate via a doubled byte so a zero shift needs no special case.
    function automatic logic [7:0] rotl8(input logic [7:0] b, input logic [2:0] s);
        logic [15:0] t;
        t = {b, b} << s;
        return t[15:8];
    endfunction

endpackage

// File: rtl/aes_sbox_lut.sv
// aes_sbox_lut: 8-bit combinational AES forward S-box.
//   x_i  in  8  S-box input
//   y_o  out 8  S-box output
module aes_sbox_lut
    import hash_pkg::*;
(
    input  logic [7:0] x_i,
    output logic [7:0] y_o
);

    assign y_o = sbox(x_i);

endmodule

// File: rtl/hash_core_param.sv
// hash_core_param: parametrised byte-stream hash.
// Absorbs bytes over a valid/ready handshake; each byte drives one S-box round
// of DIGEST_BYTES sequential state updates. Finalises with the 64-bit
// big-endian byte count and holds the digest until acknowledged.
//   clk, reset_n       clock, async active-low reset
//   start_i            begin/restart a message (any state)
//   in_valid_i/in_data_i/in_last_i  byte stream, in_ready_o high in ABSORB
//   finish_i           end message without a byte (ABSORB, in_valid_i=0)
//   busy_o             INIT/ROUND/FINAL
//   digest_o           H[k] in [8k+7:8k], zero unless digest_valid_o
//   digest_valid_o     DONE; digest_ack_i returns to IDLE
module hash_core_param
    import hash_pkg::*;
#(
    parameter int         DIGEST_BYTES = 8,
    parameter logic [7:0] IV_BYTE      = 8'h00
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start_i,
    input  logic                      in_valid_i,
    input  logic [7:0]                in_data_i,
    input  logic                      in_last_i,
    input  logic                      finish_i,
    output logic                      in_ready_o,
    output logic                      busy_o,
    output logic [8*DIGEST_BYTES-1:0] digest_o,
    output logic                      digest_valid_o,
    input  logic                      digest_ack_i
);

    localparam int             SW        = (DIGEST_BYTES > 1) ? $clog2(DIGEST_BYTES) : 1;
    localparam logic [SW-1:0]  LAST_STEP = SW'(DIGEST_BYTES - 1);
    localparam logic [2:0]     LAST_K    = 3'(LEN_BYTES - 1);

    hash_state_e                   state_q, state_d;
    logic [DIGEST_BYTES-1:0][7:0]  h_q, h_d;
    logic [63:0]                   len_q, len_d;
    logic [7:0]                    b_q, b_d;
    logic                          last_q, last_d;
    logic [SW-1:0]                 step_q, step_d;
    logic [2:0]                    k_q, k_d;

    logic                          step_last;
    logic [SW-1:0]                 nbr_idx;
    logic [7:0]                    len_byte;
    logic [7:0]                    msg_byte;
    logic [2:0]                    rot_amt;
    logic [7:0]                    sbox_in, sbox_out;

    // Shared round datapath. The neighbour index wraps so the final step
    // reads the H[0] already rewritten by step 0 of the same round.
    assign step_last = (step_q == LAST_STEP);
    assign nbr_idx   = step_last ? '0 : step_q + 1'b1;
    // len is frozen throughout FINAL, so it doubles as the count snapshot.
    assign len_byte  = len_q[{LAST_K - k_q, 3'b000} +: 8];
    assign msg_byte  = (state_q == ST_FINAL) ? len_byte : b_q;
    assign rot_amt   = 3'(step_q);
    assign sbox_in   = h_q[nbr_idx] ^ rotl8(msg_byte, rot_amt);

    aes_sbox_lut u_sbox (
        .x_i (sbox_in),
        .y_o (sbox_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            len_q   <= '0;
            b_q     <= '0;
            last_q  <= 1'b0;
            step_q  <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            len_q   <= len_d;
            b_q     <= b_d;
            last_q  <= last_d;
            step_q  <= step_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        len_d   = len_q;
        b_d     = b_q;
        last_d  = last_q;
        step_d  = step_q;
        k_d     = k_q;

        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_INIT: begin
                h_d     = {DIGEST_BYTES{IV_BYTE}};
                len_d   = '0;
                step_d  = '0;
                k_d     = '0;
                state_d = ST_ABSORB;
            end
            ST_ABSORB: begin
                // A byte takes precedence over a simultaneous finish.
                if (in_valid_i) begin
                    b_d     = in_data_i;
                    last_d  = in_last_i;
                    len_d   = len_q + 64'd1;
                    step_d  = '0;
                    state_d = ST_ROUND;
                end else if (finish_i) begin
                    step_d  = '0;
                    k_d     = '0;
                    state_d = ST_FINAL;
                end
            end
            ST_ROUND: begin
                h_d[step_q] = sbox_out;
                step_d      = nbr_idx;
                if (step_last) begin
                    k_d     = '0;
                    state_d = last_q ? ST_FINAL : ST_ABSORB;
                end
            end
            ST_FINAL: begin
                h_d[step_q] = sbox_out;
                step_d      = nbr_idx;
                if (step_last) begin
                    k_d = k_q + 3'd1;
                    if (k_q == LAST_K) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (digest_ack_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Restart wins everywhere; INIT reloads all message state, so any
        // half-finished round is simply dropped.
        if (start_i) state_d = ST_INIT;
    end

    // Outputs decode registered state only.
    assign in_ready_o     = (state_q == ST_ABSORB);
    assign busy_o         = (state_q == ST_INIT) || (state_q == ST_ROUND) || (state_q == ST_FINAL);
    assign digest_valid_o = (state_q == ST_DONE);
    assign digest_o       = (state_q == ST_DONE) ? h_q : '0;

endmodule

// File: tb/tb_hash_core_param.sv
module tb_hash_core_param;

    localparam int NI = 5;
    // Instance set: {N, IV} = {4,00} {8,00} {2,A5} {32,A5} {8,A5}
    localparam logic [NI-1:0][7:0] NS  = {8'd8, 8'd32, 8'd2, 8'd8, 8'd4};
    localparam logic [NI-1:0][7:0] IVS = {8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [NI-1:0] st = '0, iv = '0, il = '0, fin = '0, ack = '0;
    logic [NI-1:0] rdy, bsy, dv;
    logic [NI-1:0][7:0] id = '0;
    logic [255:0] dg [NI];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    byte unsigned sb[256];
    byte unsigned msg[$];
    int acc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [8*int'(NS[g])-1:0] d;
        hash_core_param #(.DIGEST_BYTES(int'(NS[g])), .IV_BYTE(IVS[g])) u_dut (
            .clk            (clk),
            .reset_n        (reset_n),
            .start_i        (st[g]),
            .in_valid_i     (iv[g]),
            .in_data_i      (id[g]),
            .in_last_i      (il[g]),
            .finish_i       (fin[g]),
            .in_ready_o     (rdy[g]),
            .busy_o         (bsy[g]),
            .digest_o       (d),
            .digest_valid_o (dv[g]),
            .digest_ack_i   (ack[g])
        );
        assign dg[g] = 256'(d);
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic byte unsigned rot(input byte unsigned b, input int s);
        return 8'((int'(b) << s) | (int'(b) >> (8 - s)));
    endfunction

    function automatic byte unsigned gmul(input byte unsigned a, input byte unsigned b);
        byte unsigned p;
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = 8'((int'(a) << 1) ^ (a[7] ? 8'h1b : 8'h00));
            b = b >> 1;
        end
        return p;
    endfunction

    // AES S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        byte unsigned inv;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'd1) inv = 8'(y);
            sb[x] = inv ^ rot(inv, 1) ^ rot(inv, 2) ^ rot(inv, 3) ^ rot(inv, 4) ^ 8'h63;
        end
    endtask

    // Digest of msg: every message byte then the 8 big-endian count bytes,
    // each applied as a round of N in-place updates.
    function automatic logic [255:0] model(input int n, input logic [7:0] ivb);
        byte unsigned h[32];
        byte unsigned q[$];
        longint unsigned len;
        logic [255:0] r;
        r = '0;
        len = longint'(msg.size());
        q = msg;
        for (int k = 0; k < 8; k++) q.push_back(8'(len >> (56 - 8 * k)));
        for (int i = 0; i < n; i++) h[i] = ivb;
        foreach (q[j])
            for (int i = 0; i < n; i++)
                h[i] = sb[h[(i + 1) % n] ^ rot(q[j], i % 8)];
        for (int i = 0; i < n; i++) r[8*i +: 8] = h[i];
        return r;
    endfunction

    // Runs msg through instance g. Entered and left at a negedge.
    task automatic run_msg(input int g, input bit use_last, input bit hold, input bit gaps,
                           input bit do_ack, input bit chk_lat, input int abort_after);
        int n, t, tend, budget;
        n = int'(NS[g]);
        acc.delete();
        @(negedge clk); st[g] = 1'b1;
        @(negedge clk); st[g] = 1'b0;
        chk("init_state", {rdy[g], bsy[g], dv[g]}, 3'b010);
        @(negedge clk);
        chk("absorb_ready", {rdy[g], bsy[g]}, 2'b10);
        for (int i = 0; i < msg.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                iv[g] = 1'b0; fin[g] = 1'b0;
                @(negedge clk);
            end
            iv[g] = 1'b1;
            id[g] = msg[i];
            il[g] = use_last && (i == msg.size() - 1);
            fin[g] = gaps && ($urandom_range(0, 1) == 1);
            budget = 4 * n + 10;
            while (!rdy[g] && budget > 0) begin @(negedge clk); budget--; end
            chk("byte_ready", rdy[g], 1'b1);
            acc.push_back(cyc + 1);
            @(posedge clk);
            @(negedge clk);
            if (!hold) begin iv[g] = 1'b0; fin[g] = 1'b0; end
        end
        iv[g] = 1'b0; il[g] = 1'b0; fin[g] = 1'b0;
        if (use_last) begin
            tend = acc[acc.size() - 1] + n + 8 * n;
        end else begin
            budget = 4 * n + 10;
            while (!rdy[g] && budget > 0) begin @(negedge clk); budget--; end
            chk("finish_ready", rdy[g], 1'b1);
            fin[g] = 1'b1;
            t = cyc + 1;
            @(posedge clk);
            @(negedge clk);
            fin[g] = 1'b0;
            tend = t + 8 * n;
        end
        if (abort_after > 0) begin
            repeat (abort_after) @(negedge clk);
            chk("final_busy", {rdy[g], bsy[g], dv[g]}, 3'b010);
            return;
        end
        budget = 9 * n + 10;
        while (!dv[g] && budget > 0) begin @(negedge clk); budget--; end
        chk("done_valid", dv[g], 1'b1);
        if (chk_lat) chk("done_latency", cyc, tend);
        chk("digest", dg[g], model(n, IVS[g]));
        if (do_ack) begin
            ack[g] = 1'b1;
            @(negedge clk);
            ack[g] = 1'b0;
            chk("ack_idle", {rdy[g], bsy[g], dv[g]}, 3'b000);
            chk("ack_digest_zero", dg[g], '0);
        end
    endtask

    initial begin
        int len, g;
        build_sbox();

        // Reset state
        #3;
        for (int i = 0; i < NI; i++) begin
            chk("reset_flags", {rdy[i], bsy[i], dv[i]}, 3'b000);
            chk("reset_digest", dg[i], '0);
        end
        #9 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) chk("idle_after_reset", {rdy[i], bsy[i], dv[i]}, 3'b000);

        // Single byte 0x00, N=4 IV=00
        msg = {8'h00};
        run_msg(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);

        // Empty message, N=8 IV=00
        msg = {};
        run_msg(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);

        // Backpressure: valid held high for 3 bytes, N=4
        msg = {8'h11, 8'h22, 8'h33};
        run_msg(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        chk("bp_count", acc.size(), 3);
        chk("bp_gap01", acc[1] - acc[0], 5);
        chk("bp_gap12", acc[2] - acc[1], 5);

        // Abort during FINAL, then "abc"
        msg = {8'h5a, 8'h5b};
        run_msg(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13);
        msg = {8'h61, 8'h62, 8'h63};
        run_msg(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);

        // Start in DONE without ack drops the digest
        msg = {8'h01};
        run_msg(4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        st[4] = 1'b1;
        @(negedge clk); st[4] = 1'b0;
        chk("restart_drop_valid", dv[4], 1'b0);
        chk("restart_drop_digest", dg[4], '0);
        chk("restart_init", bsy[4], 1'b1);

        // Ack outside DONE has no effect
        ack[2] = 1'b1;
        @(negedge clk); ack[2] = 1'b0;
        chk("ack_ignored_idle", {rdy[2], bsy[2], dv[2]}, 3'b000);

        // Asynchronous reset mid-ROUND
        @(negedge clk); st[0] = 1'b1;
        @(negedge clk); st[0] = 1'b0;
        @(negedge clk); iv[0] = 1'b1; id[0] = 8'h77; il[0] = 1'b0;
        @(negedge clk); iv[0] = 1'b0;
        chk("pre_reset_round", {rdy[0], bsy[0]}, 2'b01);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_flags", {rdy[0], bsy[0], dv[0]}, 3'b000);
        chk("async_reset_digest", dg[0], '0);
        #5 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_idle", {rdy[0], bsy[0], dv[0], rdy[4], bsy[4]}, 5'b00000);

        // Random sweep, IV=A5, N in {2,8,32}
        for (int s = 0; s < 9; s++) begin
            g = (s % 3 == 0) ? 2 : (s % 3 == 1) ? 4 : 3;
            len = (g == 3) ? $urandom_range(1, 150) : $urandom_range(1, 300);
            msg = {};
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            run_msg(g, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'b1, 1'b1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
